// File: rtl/pkt_mem_arbiter_if.sv
// pkt_mem_arbiter_if: master-side request buses and the shared memory port of the packet memory arbiter.
interface pkt_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        ce_i;
    logic [NUM_REQ-1:0]        we_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ*4-1:0]      width_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      mem_ce_o;
    logic                      mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [3:0]                mem_width_o;
    logic [DATA_W-1:0]         mem_data_o;
    logic [DATA_W-1:0]         mem_data_i;

    modport slave (
        input  req_i, ce_i, we_i, addr_i, width_i, wdata_i, mem_data_i,
        output gnt_o, rdata_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
    );

    modport master (
        output req_i, ce_i, we_i, addr_i, width_i, wdata_i, mem_data_i,
        input  gnt_o, rdata_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
    );
endinterface

// File: rtl/pkt_mem_arbiter.sv
// pkt_mem_arbiter: round-robin, burst-holding arbiter sharing one packet memory port among NUM_REQ masters.
module pkt_mem_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    pkt_mem_arbiter_if.slave   bus,
    output logic               busy_o,
    output logic               err_hold_o
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]  owner_q, owner_d, pick, idx;
    logic [HW-1:0]  hold_q, hold_d;
    logic           err_q, err_d, found;
    int             k;

    // owner_q doubles as last owner: scanning starts just past it, so it always ranks last
    always_comb begin
        pick  = owner_q;
        found = 1'b0;
        k     = 0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k   = (int'(owner_q) + i) % NUM_REQ;
            idx = OW'(k);
            if (!found && bus.req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        err_d   = err_q;
        if (state_q == BUSY) begin
            hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
            err_d  = err_q | (hold_q == HW'(MAX_HOLD - 1));
            if (!bus.req_i[owner_q]) begin
                gnt_d   = '0;
                state_d = RELEASE;
            end
        end else if (found) begin
            state_d = BUSY;
            owner_d = pick;
            gnt_d   = NUM_REQ'(1) << pick;
            hold_d  = '0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= OW'(NUM_REQ - 1);
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign busy_o          = (state_q == BUSY);
    assign err_hold_o      = err_q;
    assign bus.gnt_o       = gnt_q;
    assign bus.rdata_o     = bus.mem_data_i;
    assign bus.mem_ce_o    = busy_o & bus.ce_i[owner_q];
    assign bus.mem_we_o    = busy_o & bus.we_i[owner_q];
    assign bus.mem_addr_o  = busy_o ? bus.addr_i[int'(owner_q)*ADDR_W +: ADDR_W] : '0;
    assign bus.mem_width_o = busy_o ? bus.width_i[int'(owner_q)*4 +: 4] : '0;
    assign bus.mem_data_o  = busy_o ? bus.wdata_i[int'(owner_q)*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// tb_pkt_mem_arbiter: directed scenarios for grant latency, round-robin order, isolation, hold error and async reset.
module tb_pkt_mem_arbiter;
    logic clk, rst_n, busy, err;
    int   tot, pass;

    pkt_mem_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32)) bus ();

    pkt_mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .busy_o     (busy),
        .err_hold_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input int m, input logic ce, input logic we, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
        bus.ce_i[m]            = ce;
        bus.we_i[m]            = we;
        bus.addr_i[m*32 +: 32] = a;
        bus.width_i[m*4 +: 4]  = w;
        bus.wdata_i[m*32 +: 32] = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_i = '0; bus.ce_i = '0; bus.we_i = '0;
        bus.addr_i = '0; bus.width_i = '0; bus.wdata_i = '0; bus.mem_data_i = '0;
        tick; tick;
        tot++; if (bus.gnt_o !== 3'b000) $display("FAIL reset_gnt got=%b exp=000", bus.gnt_o); else pass++;
        tot++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
        tot++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass++;
        tot++; if (bus.mem_ce_o !== 1'b0) $display("FAIL reset_ce got=%b exp=0", bus.mem_ce_o); else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        tick;
        bus.req_i = 3'b010;
        set_m(1, 1'b1, 1'b1, 32'h40, 4'd4, 32'hDEADBEEF);
        #1;
        tot++; if (bus.gnt_o !== 3'b000) $display("FAIL t1_early_gnt got=%b exp=000", bus.gnt_o); else pass++;
        tot++; if (bus.mem_ce_o !== 1'b0) $display("FAIL t1_early_ce got=%b exp=0", bus.mem_ce_o); else pass++;
        tick;
        tot++; if (bus.gnt_o !== 3'b010) $display("FAIL t1_gnt got=%b exp=010", bus.gnt_o); else pass++;
        tot++; if (busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", busy); else pass++;
        tot++; if (bus.mem_ce_o !== 1'b1 || bus.mem_we_o !== 1'b1)
            $display("FAIL t1_cewe got=%b%b exp=11", bus.mem_ce_o, bus.mem_we_o); else pass++;
        tot++; if (bus.mem_addr_o !== 32'h40) $display("FAIL t1_addr got=%h exp=00000040", bus.mem_addr_o); else pass++;
        tot++; if (bus.mem_width_o !== 4'd4) $display("FAIL t1_width got=%0d exp=4", bus.mem_width_o); else pass++;
        tot++; if (bus.mem_data_o !== 32'hDEADBEEF) $display("FAIL t1_wdata got=%h exp=deadbeef", bus.mem_data_o); else pass++;
        bus.mem_data_i = 32'hCAFEF00D;
        #1;
        tot++; if (bus.rdata_o !== 32'hCAFEF00D) $display("FAIL t1_rdata got=%h exp=cafef00d", bus.rdata_o); else pass++;
        bus.req_i = '0;
        tick;
        tot++; if (bus.gnt_o !== 3'b000 || busy !== 1'b0)
            $display("FAIL t1_release got=%b/%b exp=000/0", bus.gnt_o, busy); else pass++;
        tot++; if (bus.mem_ce_o !== 1'b0 || bus.mem_addr_o !== 32'h0)
            $display("FAIL t1_release_port got=%b/%h exp=0/00000000", bus.mem_ce_o, bus.mem_addr_o); else pass++;
        set_m(1, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
        tick;
    endtask

    task automatic test_round_robin;
        int ord[4] = '{0, 1, 2, 0};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int m = 0; m < 3; m++) set_m(m, 1'b1, 1'b0, 32'h100 + 32'(m) * 32'h10, 4'd4, 32'h0);
        bus.req_i = 3'b111;
        for (int g = 0; g < 4; g++) begin
            tick;
            tot++; if (bus.gnt_o !== 3'(1 << ord[g])) $display("FAIL t2_gnt%0d got=%b exp=%b", g, bus.gnt_o, 3'(1 << ord[g])); else pass++;
            tot++; if (bus.mem_addr_o !== 32'h100 + 32'(ord[g]) * 32'h10)
                $display("FAIL t2_addr%0d got=%h exp=%h", g, bus.mem_addr_o, 32'h100 + 32'(ord[g]) * 32'h10); else pass++;
            tick; tick; tick;
            tot++; if (bus.gnt_o !== 3'(1 << ord[g])) $display("FAIL t2_hold%0d got=%b exp=%b", g, bus.gnt_o, 3'(1 << ord[g])); else pass++;
            bus.req_i[ord[g]] = 1'b0;
            tick;
            tot++; if (bus.gnt_o !== 3'b000 || bus.mem_ce_o !== 1'b0)
                $display("FAIL t2_gap%0d got=%b/%b exp=000/0", g, bus.gnt_o, bus.mem_ce_o); else pass++;
            bus.req_i[ord[g]] = 1'b1;
        end
        bus.req_i = '0;
        tick;
    endtask

    task automatic test_isolation;
        set_m(0, 1'b1, 1'b0, 32'h10, 4'd2, 32'h11);
        set_m(2, 1'b1, 1'b1, 32'h99, 4'd1, 32'h22);
        bus.req_i = 3'b001;
        tick;
        tot++; if (bus.gnt_o !== 3'b001) $display("FAIL t3_gnt got=%b exp=001", bus.gnt_o); else pass++;
        tot++; if (bus.mem_addr_o !== 32'h10 || bus.mem_we_o !== 1'b0)
            $display("FAIL t3_port got=%h/%b exp=00000010/0", bus.mem_addr_o, bus.mem_we_o); else pass++;
        bus.req_i[2] = 1'b1;
        tick;
        tot++; if (bus.gnt_o !== 3'b001 || bus.mem_addr_o !== 32'h10)
            $display("FAIL t3_keep got=%b/%h exp=001/00000010", bus.gnt_o, bus.mem_addr_o); else pass++;
        bus.we_i[0] = 1'b1;
        #1;
        tot++; if (bus.mem_we_o !== 1'b1) $display("FAIL t3_we_follow got=%b exp=1", bus.mem_we_o); else pass++;
        bus.ce_i[0] = 1'b0;
        #1;
        tot++; if (bus.mem_ce_o !== 1'b0 || bus.gnt_o !== 3'b001)
            $display("FAIL t3_ce_low got=%b/%b exp=0/001", bus.mem_ce_o, bus.gnt_o); else pass++;
        bus.req_i[0] = 1'b0;
        tick;
        tick;
        tot++; if (bus.gnt_o !== 3'b100 || bus.mem_addr_o !== 32'h99)
            $display("FAIL t3_next got=%b/%h exp=100/00000099", bus.gnt_o, bus.mem_addr_o); else pass++;
        bus.req_i = '0;
        tick;
        tick;
    endtask

    task automatic test_rerequest;
        bus.req_i = 3'b010;
        tick;
        tot++; if (bus.gnt_o !== 3'b010) $display("FAIL t5_first got=%b exp=010", bus.gnt_o); else pass++;
        bus.req_i = 3'b001;
        tick;
        bus.req_i = 3'b011;
        tick;
        tot++; if (bus.gnt_o !== 3'b001) $display("FAIL t5_m0_first got=%b exp=001", bus.gnt_o); else pass++;
        bus.req_i = 3'b010;
        tick;
        tick;
        tot++; if (bus.gnt_o !== 3'b010) $display("FAIL t5_m1_after got=%b exp=010", bus.gnt_o); else pass++;
        bus.req_i = '0;
        tick;
        tick;
    endtask

    task automatic test_hold_err;
        bus.req_i = 3'b100;
        tick;
        for (int n = 1; n <= 20; n++) begin
            tot++; if (bus.gnt_o !== 3'b100) $display("FAIL t4_gnt_c%0d got=%b exp=100", n, bus.gnt_o); else pass++;
            tot++; if (err !== (n >= 9)) $display("FAIL t4_err_c%0d got=%b exp=%b", n, err, n >= 9); else pass++;
            if (n == 20) bus.req_i = '0;
            tick;
        end
        tot++; if (err !== 1'b1 || bus.gnt_o !== 3'b000)
            $display("FAIL t4_sticky got=%b/%b exp=1/000", err, bus.gnt_o); else pass++;
        tick;
        tot++; if (err !== 1'b1) $display("FAIL t4_sticky_idle got=%b exp=1", err); else pass++;
    endtask

    task automatic test_async_reset;
        set_m(0, 1'b1, 1'b1, 32'h200, 4'd4, 32'h12345678);
        bus.req_i = 3'b001;
        tick;
        tot++; if (bus.gnt_o !== 3'b001 || bus.mem_we_o !== 1'b1)
            $display("FAIL t6_burst got=%b/%b exp=001/1", bus.gnt_o, bus.mem_we_o); else pass++;
        #1;
        rst_n = 1'b0;
        #1;
        tot++; if (bus.gnt_o !== 3'b000 || bus.mem_we_o !== 1'b0 || bus.mem_ce_o !== 1'b0)
            $display("FAIL t6_async got=%b/%b/%b exp=000/0/0", bus.gnt_o, bus.mem_we_o, bus.mem_ce_o); else pass++;
        tot++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL t6_flags got=%b/%b exp=0/0", busy, err); else pass++;
        #1;
        rst_n = 1'b1;
        bus.req_i = 3'b100;
        tick;
        tot++; if (bus.gnt_o !== 3'b100) $display("FAIL t6_regrant got=%b exp=100", bus.gnt_o); else pass++;
        bus.req_i = '0;
        tick;
        tick;
    endtask

    initial begin
        tot = 0;
        pass = 0;
        test_reset;
        test_single;
        test_round_robin;
        test_isolation;
        test_rerequest;
        test_hold_err;
        test_async_reset;
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule
